bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-port arbiter that shares one external memory bus between the instruction-fetch port and the data port of `riscv_core`. It turns the core's two independent request streams into a single serialized memory transaction stream with a valid/ready handshake. Arbitration between the ports is round-robin. A per-transaction timeout guards against a hung bus. It sits between `riscv_core` (plus its fetch logic) and the system RAM/peripheral bus; the core stalls on any port whose ack has not yet returned.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 16, wait cycles allowed per transaction before abort; 0 disables the timeout; legal range 0..255.

Ports:
- `clock`  in  1  — sole clock; all logic on rising edge.
- `reset`  in  1  — synchronous, active-high.
- `ibus_req`  in  1  — fetch request; held high until `ibus_ack`.
- `ibus_addr`  in  32  — fetch address; stable while requesting.
- `ibus_ack`  out  1  — one-cycle completion pulse.
- `ibus_rdata`  out  32  — fetched word; valid with `ibus_ack`, held until the next fetch completes.
- `dbus_req`  in  1  — data request; held high until `dbus_ack`.
- `dbus_we`  in  1  — 1 = write.
- `dbus_addr`  in  32  — data address.
- `dbus_wdata`  in  32  — write data.
- `dbus_byte_enable`  in  4  — byte lanes.
- `dbus_ack`  out  1  — one-cycle completion pulse.
- `dbus_rdata`  out  32  — read data; valid with `dbus_ack`; unchanged by writes.
- `mem_valid`  out  1  — transaction in flight.
- `mem_we`  out  1  — write strobe.
- `mem_addr`  out  32  — bus address.
- `mem_wdata`  out  32  — bus write data.
- `mem_byte_enable`  out  4  — bus byte lanes.
- `mem_ready`  in  1  — memory completes the transaction in the same cycle.
- `mem_rdata`  in  32  — read data; valid when `mem_ready` is high.
- `bus_error`  out  1  — one-cycle pulse with the ack of a timed-out transaction.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D. A `last_grant` flag records the last port served (I or D).
- IDLE:
  - A port is eligible when its req is high and its ack is not high in the current cycle. This prevents re-granting a request whose ack is being returned.
  - One eligible port → grant it.
  - Both eligible → grant the port that is not `last_grant`.
  - On grant: latch addr/we/wdata/byte_enable into the `mem_*` registers; go to BUSY_I or BUSY_D; update `last_grant`; clear the wait counter.
- Fetch transactions always drive `mem_we`=0 and `mem_byte_enable`=4'b1111; `mem_wdata` is driven to 0.
- BUSY_x:
  - `mem_valid`=1 and all `mem_*` outputs stay stable; the requester's inputs are not re-sampled.
  - `mem_ready`=1 → capture `mem_rdata` into `x_rdata` (read transactions only); pulse `x_ack` next cycle; go to IDLE.
  - `mem_ready`=0 → increment the 8-bit wait counter.
  - If `TIMEOUT_CYCLES`≠0 and the counter reaches `TIMEOUT_CYCLES`: abort the transaction, go to IDLE, pulse `x_ack` and `bus_error` next cycle, and load `x_rdata` with 0.
- A requester that drops req mid-transaction is ignored: the transaction completes and ack still pulses.
- `mem_ready` is ignored while in IDLE.

## Timing
- Reset values: state IDLE, `last_grant`=D (so fetch wins the first conflict), wait counter 0. All outputs are 0: `mem_valid`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_byte_enable`, both acks, both rdata, `bus_error`.
- Reset mid-transaction: the in-flight transaction is discarded with no ack and no error; `mem_valid` is 0 from the cycle after the reset edge.
- Latency, with req first seen high in IDLE at cycle N:
  - `mem_valid` is high at N+1.
  - If `mem_ready` is high at N+1+k, ack is high at N+2+k.
  - Minimum request-to-ack is 2 cycles.
- Back-to-back service: the other port can be granted in the ack cycle, so `mem_valid` reasserts at ack+1. The same port can be re-granted at ack+1 (its req is eligible again then).
- Timeout: with `mem_ready` held 0, the abort decision happens at cycle N+`TIMEOUT_CYCLES`, giving `mem_valid` high for `TIMEOUT_CYCLES` cycles. Ack and `bus_error` follow one cycle later.
- At most one ack is high in any cycle. `bus_error` is only ever high together with an ack.

## Test plan
- Single fetch, zero wait: `ibus_req`=1, addr 0x100, `mem_ready`=1 with `mem_rdata`=0x00500093 → `mem_valid` high for 1 cycle with `mem_addr`=0x100, `mem_we`=0, byte enable 0xF; `ibus_ack` at N+2 with `ibus_rdata`=0x00500093.
- Conflict after reset: `ibus_req` and `dbus_req` rise together → fetch served first, then data. Repeat the conflict → fetch first again (round-robin alternates only after a data grant; `last_grant` is now D).
- Data write with 3 wait states: `dbus_we`=1, addr 0x2000, wdata 0xCAFEF00D, byte enable 0x3 → `mem_*` stable for 4 cycles; `dbus_ack` at N+5; `dbus_rdata` unchanged.
- Timeout: `TIMEOUT_CYCLES`=4, `mem_ready` stuck at 0 on a read → `mem_valid` high for exactly 4 cycles; `dbus_ack` and `bus_error` pulse together; `dbus_rdata`=0.
- No double grant: `ibus_req` held high through its ack → exactly one transaction before the ack, and the next `mem_valid` comes no earlier than ack+1.
- Reset mid-transaction: assert `reset` at BUSY_D wait cycle 2 → no ack, `mem_valid`=0 the next cycle, and the first conflict after reset goes to fetch.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Signal bundle between the core's fetch/data ports, the arbiter and the memory bus.
// "master" is the arbiter's view; "slave" is the view of the core plus memory around it.
interface bus_arbiter_if;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack;
  logic [31:0] ibus_rdata;

  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_byte_enable;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        bus_error;

  modport master (
    input  ibus_req, ibus_addr,
    output ibus_ack, ibus_rdata,
    input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_byte_enable,
    output dbus_ack, dbus_rdata,
    output mem_valid, mem_we, mem_addr, mem_wdata, mem_byte_enable,
    input  mem_ready, mem_rdata,
    output bus_error
  );

  modport slave (
    output ibus_req, ibus_addr,
    input  ibus_ack, ibus_rdata,
    output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_byte_enable,
    input  dbus_ack, dbus_rdata,
    input  mem_valid, mem_we, mem_addr, mem_wdata, mem_byte_enable,
    output mem_ready, mem_rdata,
    input  bus_error
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter serialising the core's fetch and data ports onto a single
// valid/ready memory bus, with a per-transaction wait timeout.
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic           clock,
  input logic           reset,
  bus_arbiter_if.master bus
);

  localparam bit         TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       last_grant_d;
  logic       last_grant_d_next;
  logic [7:0] wait_count;
  logic       i_eligible;
  logic       d_eligible;
  logic       grant_i;
  logic       grant_d;
  logic       finish_ok;
  logic       finish_abort;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
    end else begin
      state        <= state_next;
      last_grant_d <= last_grant_d_next;
    end
  end

  // A port whose ack is on the wire this cycle is still holding its old request, so it is not eligible.
  always_comb begin
    state_next        = state;
    last_grant_d_next = last_grant_d;
    grant_i           = 1'b0;
    grant_d           = 1'b0;
    finish_ok         = 1'b0;
    finish_abort      = 1'b0;
    i_eligible        = bus.ibus_req && !bus.ibus_ack;
    d_eligible        = bus.dbus_req && !bus.dbus_ack;
    case (state)
      IDLE: begin
        if (i_eligible && (!d_eligible || last_grant_d)) begin
          grant_i           = 1'b1;
          state_next        = BUSY_I;
          last_grant_d_next = 1'b0;
        end else if (d_eligible) begin
          grant_d           = 1'b1;
          state_next        = BUSY_D;
          last_grant_d_next = 1'b1;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_ready) begin
          finish_ok  = 1'b1;
          state_next = IDLE;
        end else if (TIMEOUT_EN && wait_count == TIMEOUT_LAST) begin
          finish_abort = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.mem_valid = (state != IDLE);

  // Bus registers are loaded only on grant, so they stay frozen for the whole transaction.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_count          <= '0;
      bus.mem_we          <= 1'b0;
      bus.mem_addr        <= '0;
      bus.mem_wdata       <= '0;
      bus.mem_byte_enable <= '0;
      bus.ibus_ack        <= 1'b0;
      bus.ibus_rdata      <= '0;
      bus.dbus_ack        <= 1'b0;
      bus.dbus_rdata      <= '0;
      bus.bus_error       <= 1'b0;
    end else begin
      bus.ibus_ack  <= (state == BUSY_I) && (finish_ok || finish_abort);
      bus.dbus_ack  <= (state == BUSY_D) && (finish_ok || finish_abort);
      bus.bus_error <= finish_abort;

      if (grant_i) begin
        wait_count          <= '0;
        bus.mem_we          <= 1'b0;
        bus.mem_addr        <= bus.ibus_addr;
        bus.mem_wdata       <= '0;
        bus.mem_byte_enable <= 4'b1111;
      end else if (grant_d) begin
        wait_count          <= '0;
        bus.mem_we          <= bus.dbus_we;
        bus.mem_addr        <= bus.dbus_addr;
        bus.mem_wdata       <= bus.dbus_wdata;
        bus.mem_byte_enable <= bus.dbus_byte_enable;
      end else if (state != IDLE && !bus.mem_ready) begin
        wait_count <= wait_count + 8'd1;
      end

      if (state == BUSY_I) begin
        if (finish_ok) begin
          bus.ibus_rdata <= bus.mem_rdata;
        end else if (finish_abort) begin
          bus.ibus_rdata <= '0;
        end
      end

      if (state == BUSY_D) begin
        if (finish_ok && !bus.mem_we) begin
          bus.dbus_rdata <= bus.mem_rdata;
        end else if (finish_abort) begin
          bus.dbus_rdata <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios with literal expectations, then random
// traffic compared every cycle against a transaction-level model.
module tb_bus_arbiter;

  localparam int TIMEOUT = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   stall_left = 0;

  bus_arbiter_if bus ();

  bus_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Model: which port owns the bus (0 none, 1 fetch, 2 data), who was served last, wait cycles so far.
  int          busy_port = 0;
  int          last_port = 2;
  int          waited = 0;
  logic [31:0] txn_addr = '0;
  logic [31:0] txn_wdata = '0;
  logic        txn_we = 1'b0;
  logic [3:0]  txn_be = '0;
  logic        exp_iack = 1'b0;
  logic        exp_dack = 1'b0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_irdata = '0;
  logic [31:0] exp_drdata = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelEdge();
    logic i_ok;
    logic d_ok;
    logic done;
    logic abort;
    int   pick;
    i_ok     = bus.ibus_req && !exp_iack;
    d_ok     = bus.dbus_req && !exp_dack;
    exp_iack = 1'b0;
    exp_dack = 1'b0;
    exp_err  = 1'b0;
    if (reset) begin
      busy_port  = 0;
      last_port  = 2;
      waited     = 0;
      exp_irdata = '0;
      exp_drdata = '0;
    end else if (busy_port == 0) begin
      pick = 0;
      if (i_ok && d_ok) pick = 3 - last_port;
      else if (i_ok) pick = 1;
      else if (d_ok) pick = 2;
      if (pick == 1) begin
        txn_addr  = bus.ibus_addr;
        txn_we    = 1'b0;
        txn_wdata = '0;
        txn_be    = 4'hF;
      end else if (pick == 2) begin
        txn_addr  = bus.dbus_addr;
        txn_we    = bus.dbus_we;
        txn_wdata = bus.dbus_wdata;
        txn_be    = bus.dbus_byte_enable;
      end
      if (pick != 0) begin
        busy_port = pick;
        last_port = pick;
        waited    = 0;
      end
    end else begin
      done  = 1'b0;
      abort = 1'b0;
      if (bus.mem_ready) begin
        done = 1'b1;
      end else begin
        waited++;
        if (TIMEOUT != 0 && waited == TIMEOUT) begin
          done  = 1'b1;
          abort = 1'b1;
        end
      end
      if (done) begin
        if (busy_port == 1) begin
          exp_iack   = 1'b1;
          exp_irdata = abort ? 32'h0 : bus.mem_rdata;
        end else begin
          exp_dack = 1'b1;
          if (abort) exp_drdata = 32'h0;
          else if (!txn_we) exp_drdata = bus.mem_rdata;
        end
        exp_err   = abort;
        busy_port = 0;
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("mem_valid", bus.mem_valid, busy_port != 0);
    if (busy_port != 0) begin
      checkOutput("mem_addr", bus.mem_addr, txn_addr);
      checkOutput("mem_we", bus.mem_we, txn_we);
      checkOutput("mem_wdata", bus.mem_wdata, txn_wdata);
      checkOutput("mem_byte_enable", bus.mem_byte_enable, txn_be);
    end
    checkOutput("ibus_ack", bus.ibus_ack, exp_iack);
    checkOutput("dbus_ack", bus.dbus_ack, exp_dack);
    checkOutput("bus_error", bus.bus_error, exp_err);
    checkOutput("ibus_rdata", bus.ibus_rdata, exp_irdata);
    checkOutput("dbus_rdata", bus.dbus_rdata, exp_drdata);
    checkOutput("ack_exclusive", bus.ibus_ack & bus.dbus_ack, 1'b0);
    checkOutput("error_with_ack", bus.bus_error & ~(bus.ibus_ack | bus.dbus_ack), 1'b0);
  endtask

  task automatic step();
    @(posedge clock);
    modelEdge();
    #1;
    compareAll();
  endtask

  // Random requesters hold req until ack, may re-request at ack, and occasionally drop mid-transaction.
  task automatic applyStimulus();
    reset = ($urandom_range(0, 399) == 0);
    if (stall_left > 0) begin
      bus.mem_ready = 1'b0;
      stall_left--;
    end else if ($urandom_range(0, 29) == 0) begin
      stall_left    = $urandom_range(3, 7);
      bus.mem_ready = 1'b0;
    end else begin
      bus.mem_ready = ($urandom_range(0, 2) != 0);
    end
    bus.mem_rdata = $urandom;

    if (!bus.ibus_req || exp_iack) begin
      if ($urandom_range(0, 1) == 0) begin
        bus.ibus_req  = 1'b1;
        bus.ibus_addr = $urandom & 32'hFFFF_FFFC;
      end else begin
        bus.ibus_req = 1'b0;
      end
    end else if (busy_port == 1 && $urandom_range(0, 24) == 0) begin
      bus.ibus_req = 1'b0;
    end

    if (!bus.dbus_req || exp_dack) begin
      if ($urandom_range(0, 1) == 0) begin
        bus.dbus_req         = 1'b1;
        bus.dbus_we          = 1'($urandom_range(0, 1));
        bus.dbus_addr        = $urandom;
        bus.dbus_wdata       = $urandom;
        bus.dbus_byte_enable = 4'($urandom_range(1, 15));
      end else begin
        bus.dbus_req = 1'b0;
      end
    end else if (busy_port == 2 && $urandom_range(0, 24) == 0) begin
      bus.dbus_req = 1'b0;
    end
  endtask

  initial begin
    bus.ibus_req         = 1'b0;
    bus.ibus_addr        = '0;
    bus.dbus_req         = 1'b0;
    bus.dbus_we          = 1'b0;
    bus.dbus_addr        = '0;
    bus.dbus_wdata       = '0;
    bus.dbus_byte_enable = '0;
    bus.mem_ready        = 1'b0;
    bus.mem_rdata        = '0;

    $display("[TB] reset state");
    reset = 1'b1;
    step();
    step();
    checkOutput("rst_mem_valid", bus.mem_valid, 1'b0);
    checkOutput("rst_mem_we", bus.mem_we, 1'b0);
    checkOutput("rst_mem_addr", bus.mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", bus.mem_wdata, 32'h0);
    checkOutput("rst_mem_be", bus.mem_byte_enable, 4'h0);
    checkOutput("rst_acks", {bus.ibus_ack, bus.dbus_ack, bus.bus_error}, 3'b000);
    checkOutput("rst_ibus_rdata", bus.ibus_rdata, 32'h0);
    checkOutput("rst_dbus_rdata", bus.dbus_rdata, 32'h0);

    $display("[TB] conflict after reset");
    reset                = 1'b0;
    bus.ibus_req         = 1'b1;
    bus.ibus_addr        = 32'h200;
    bus.dbus_req         = 1'b1;
    bus.dbus_we          = 1'b0;
    bus.dbus_addr        = 32'h40;
    bus.dbus_byte_enable = 4'hF;
    bus.mem_ready        = 1'b1;
    step();
    checkOutput("conflict1_fetch_first", bus.mem_addr, 32'h200);
    bus.mem_rdata = 32'h1111_1111;
    step();
    checkOutput("conflict1_iack", bus.ibus_ack, 1'b1);
    checkOutput("conflict1_irdata", bus.ibus_rdata, 32'h1111_1111);
    bus.ibus_req = 1'b0;
    step();
    checkOutput("conflict1_data_valid", bus.mem_valid, 1'b1);
    checkOutput("conflict1_data_addr", bus.mem_addr, 32'h40);
    bus.mem_rdata = 32'h2222_2222;
    step();
    checkOutput("conflict1_dack", bus.dbus_ack, 1'b1);
    checkOutput("conflict1_drdata", bus.dbus_rdata, 32'h2222_2222);
    bus.dbus_req = 1'b0;
    step();
    bus.ibus_req  = 1'b1;
    bus.ibus_addr = 32'h300;
    bus.dbus_req  = 1'b1;
    bus.dbus_addr = 32'h44;
    step();
    checkOutput("conflict2_fetch_first", bus.mem_addr, 32'h300);
    step();
    checkOutput("conflict2_iack", bus.ibus_ack, 1'b1);
    bus.ibus_req = 1'b0;
    step();
    checkOutput("conflict2_data_addr", bus.mem_addr, 32'h44);
    bus.mem_rdata = 32'h3333_3333;
    step();
    checkOutput("conflict2_dack", bus.dbus_ack, 1'b1);
    bus.dbus_req = 1'b0;
    step();

    $display("[TB] single fetch and no double grant");
    bus.ibus_req  = 1'b1;
    bus.ibus_addr = 32'h100;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0050_0093;
    step();
    checkOutput("fetch_valid", bus.mem_valid, 1'b1);
    checkOutput("fetch_addr", bus.mem_addr, 32'h100);
    checkOutput("fetch_we", bus.mem_we, 1'b0);
    checkOutput("fetch_be", bus.mem_byte_enable, 4'hF);
    step();
    checkOutput("fetch_ack", bus.ibus_ack, 1'b1);
    checkOutput("fetch_rdata", bus.ibus_rdata, 32'h0050_0093);
    checkOutput("fetch_valid_one_cycle", bus.mem_valid, 1'b0);
    bus.mem_rdata = 32'h00A0_0113;
    step();
    checkOutput("no_double_grant", bus.mem_valid, 1'b0);
    step();
    checkOutput("regrant_valid", bus.mem_valid, 1'b1);
    step();
    checkOutput("regrant_ack", bus.ibus_ack, 1'b1);
    checkOutput("regrant_rdata", bus.ibus_rdata, 32'h00A0_0113);
    bus.ibus_req = 1'b0;
    step();

    $display("[TB] data write with three wait states");
    bus.dbus_req         = 1'b1;
    bus.dbus_we          = 1'b1;
    bus.dbus_addr        = 32'h2000;
    bus.dbus_wdata       = 32'hCAFE_F00D;
    bus.dbus_byte_enable = 4'h3;
    bus.mem_ready        = 1'b0;
    bus.mem_rdata        = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("write_valid", bus.mem_valid, 1'b1);
      checkOutput("write_addr", bus.mem_addr, 32'h2000);
      checkOutput("write_wdata", bus.mem_wdata, 32'hCAFE_F00D);
      checkOutput("write_we_be", {bus.mem_we, bus.mem_byte_enable}, 5'b1_0011);
      checkOutput("write_no_early_ack", bus.dbus_ack, 1'b0);
    end
    bus.mem_ready = 1'b1;
    step();
    checkOutput("write_ack", bus.dbus_ack, 1'b1);
    checkOutput("write_rdata_kept", bus.dbus_rdata, 32'h3333_3333);
    checkOutput("write_no_error", bus.bus_error, 1'b0);
    bus.dbus_req  = 1'b0;
    bus.dbus_we   = 1'b0;
    bus.mem_ready = 1'b0;
    step();

    $display("[TB] timeout on a read");
    bus.dbus_req         = 1'b1;
    bus.dbus_addr        = 32'h3000;
    bus.dbus_byte_enable = 4'hF;
    for (int i = 0; i < TIMEOUT; i++) begin
      step();
      checkOutput("timeout_valid", bus.mem_valid, 1'b1);
    end
    step();
    checkOutput("timeout_valid_drop", bus.mem_valid, 1'b0);
    checkOutput("timeout_ack_err", {bus.dbus_ack, bus.bus_error}, 2'b11);
    checkOutput("timeout_rdata", bus.dbus_rdata, 32'h0);
    bus.dbus_req = 1'b0;
    step();

    $display("[TB] reset mid-transaction");
    bus.dbus_req  = 1'b1;
    bus.dbus_addr = 32'h4000;
    step();
    step();
    reset = 1'b1;
    step();
    checkOutput("midreset_valid", bus.mem_valid, 1'b0);
    checkOutput("midreset_no_ack", {bus.ibus_ack, bus.dbus_ack, bus.bus_error}, 3'b000);
    reset         = 1'b0;
    bus.ibus_req  = 1'b1;
    bus.ibus_addr = 32'h500;
    bus.dbus_addr = 32'h600;
    bus.mem_ready = 1'b1;
    step();
    checkOutput("midreset_fetch_first", bus.mem_addr, 32'h500);
    step();
    bus.ibus_req = 1'b0;
    step();
    checkOutput("midreset_data_second", bus.mem_addr, 32'h600);
    step();
    bus.dbus_req  = 1'b0;
    bus.mem_ready = 1'b0;
    step();

    $display("[TB] random traffic");
    for (int n = 0; n < 4000; n++) begin
      applyStimulus();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
